cpu_run_controller: RTL

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

---
 rtl/cpu_run_pkg.sv | 20 ++
 rtl/cpu_breakpoint_match.sv | 55 +++++
 rtl/cpu_run_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg -- shared definitions for the CPU run controller.
//   Command encodings carried on i_cmd, FSM state encoding, and a helper
//   that sizes breakpoint index fields (never narrower than one bit).
package cpu_run_pkg;

    typedef logic [1:0] cpu_cmd_t;

    localparam cpu_cmd_t CMD_HALT     = 2'd0;
    localparam cpu_cmd_t CMD_STEP     = 2'd1;
    localparam cpu_cmd_t CMD_RUN_N    = 2'd2;
    localparam cpu_cmd_t CMD_RUN_FREE = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int bp_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_breakpoint_match.sv
// cpu_breakpoint_match -- breakpoint slot storage and priority address match.
//   i_clk, i_reset      : clock, synchronous active-high reset (clears all slots)
//   i_wr_en/i_wr_index/i_wr_addr/i_wr_enable : slot write; out-of-range index dropped
//   i_cpu_address       : address compared against every enabled slot
//   hit, index          : any enabled slot matches; lowest matching slot number
// The match is combinational from the stored slots, so a write is visible
// on the cycle after i_wr_en.
module cpu_breakpoint_match
    import cpu_run_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int NUM_BREAKPOINTS = 4,
    localparam int IDX_W          = bp_idx_width(NUM_BREAKPOINTS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_index,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic                  i_wr_enable,
    input  logic [ADDR_WIDTH-1:0] i_cpu_address,
    output logic                  hit,
    output logic [IDX_W-1:0]      index
);

    logic [NUM_BREAKPOINTS-1:0][ADDR_WIDTH-1:0] slot_addr;
    logic [NUM_BREAKPOINTS-1:0]                 slot_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            slot_addr <= '0;
            slot_en   <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
                if (int'(i_wr_index) == i) begin
                    slot_addr[i] <= i_wr_addr;
                    slot_en[i]   <= i_wr_enable;
                end
            end
        end
    end

    // Scan from the top down so the lowest matching slot is the last writer.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_addr[i] == i_cpu_address)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller -- paces a CPU by issuing clock-enable pulses on a
// prescaled tick, under HALT / STEP / RUN_N / RUN_FREE commands.
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_cmd_valid, i_cmd, i_cmd_count: command strobe, opcode, RUN_N count
//   i_bp_wr_en/index/addr/enable   : breakpoint slot write
//   i_cpu_address, i_cpu_sync      : CPU bus state for breakpoint matching
//   o_cpu_clk_en                   : one-cycle CPU clock enable (combinational)
//   o_busy                         : running
//   o_done, o_cmd_error            : one-cycle pulses (end of command, rejected command)
//   o_bp_hit, o_bp_index           : breakpoint stop flag and slot, held until next command
//   o_cycles                       : enables issued for the current command (wraps)
// Build option: CPU_RUN_BREAKPOINTS_EN enables breakpoint storage and stops;
// without it the breakpoint inputs are ignored and o_bp_hit/o_bp_index stay 0.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int NUM_BREAKPOINTS = 4,
    parameter int COUNT_WIDTH     = 16,
    parameter int CLK_DIV         = 20,
    localparam int IDX_W          = bp_idx_width(NUM_BREAKPOINTS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    input  logic [1:0]             i_cmd,
    input  logic [COUNT_WIDTH-1:0] i_cmd_count,
    input  logic                   i_bp_wr_en,
    input  logic [IDX_W-1:0]       i_bp_index,
    input  logic [ADDR_WIDTH-1:0]  i_bp_addr,
    input  logic                   i_bp_enable,
    input  logic [ADDR_WIDTH-1:0]  i_cpu_address,
    input  logic                   i_cpu_sync,
    output logic                   o_cpu_clk_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cmd_error,
    output logic                   o_bp_hit,
    output logic [IDX_W-1:0]       o_bp_index,
    output logic [COUNT_WIDTH-1:0] o_cycles
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // ---------------- prescaler ----------------
    logic [PS_W-1:0] prescaler;
    logic            tick;

    assign tick = (prescaler == PS_W'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset)   prescaler <= '0;
        else if (tick) prescaler <= '0;
        else           prescaler <= prescaler + 1'b1;
    end

    // ---------------- breakpoint match ----------------
    logic             bp_match;
    logic [IDX_W-1:0] bp_match_idx;

`ifdef CPU_RUN_BREAKPOINTS_EN
    logic bp_addr_hit;

    cpu_breakpoint_match #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_BREAKPOINTS (NUM_BREAKPOINTS)
    ) u_bp (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_wr_en       (i_bp_wr_en),
        .i_wr_index    (i_bp_index),
        .i_wr_addr     (i_bp_addr),
        .i_wr_enable   (i_bp_enable),
        .i_cpu_address (i_cpu_address),
        .hit           (bp_addr_hit),
        .index         (bp_match_idx)
    );

    // Only an instruction fetch (sync) counts as reaching the breakpoint.
    assign bp_match = bp_addr_hit & i_cpu_sync;
`else
    logic unused_bp;

    assign unused_bp    = ^{i_bp_wr_en, i_bp_index, i_bp_addr, i_bp_enable,
                            i_cpu_address, i_cpu_sync};
    assign bp_match     = 1'b0;
    assign bp_match_idx = '0;
`endif

    // ---------------- run FSM ----------------
    logic [0:0]             state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   free_run;
    logic                   first_tick;   // no enable issued yet for this command
    logic                   cmd_halt;
    logic                   cmd_other;
    logic                   bp_stop;
    logic                   issue_en;

    assign o_busy    = (state == ST_RUN);
    assign cmd_halt  = i_cmd_valid && (i_cmd == CMD_HALT);
    assign cmd_other = i_cmd_valid && (i_cmd != CMD_HALT);

    // The first tick of a command skips breakpoints so a STEP can move the
    // CPU off the address it stopped on. HALT outranks both.
    assign bp_stop      = o_busy && tick && !first_tick && bp_match && !cmd_halt;
    assign issue_en     = o_busy && tick && !cmd_halt && !bp_stop;
    assign o_cpu_clk_en = issue_en && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            free_run    <= 1'b0;
            first_tick  <= 1'b0;
            o_cycles    <= '0;
            o_done      <= 1'b0;
            o_cmd_error <= 1'b0;
            o_bp_hit    <= 1'b0;
            o_bp_index  <= '0;
        end else begin
            o_done      <= 1'b0;
            o_cmd_error <= 1'b0;
            if (state == ST_IDLE) begin
                if (cmd_other) begin
                    o_cycles   <= '0;
                    o_bp_hit   <= 1'b0;
                    o_bp_index <= '0;
                    first_tick <= 1'b1;
                    free_run   <= 1'b0;
                    case (i_cmd)
                        CMD_STEP: begin
                            remaining <= COUNT_WIDTH'(1);
                            state     <= ST_RUN;
                        end
                        CMD_RUN_N: begin
                            // A zero-length run finishes immediately without running.
                            if (i_cmd_count == '0) begin
                                o_done <= 1'b1;
                            end else begin
                                remaining <= i_cmd_count;
                                state     <= ST_RUN;
                            end
                        end
                        default: begin
                            remaining <= '0;
                            free_run  <= 1'b1;
                            state     <= ST_RUN;
                        end
                    endcase
                end
            end else begin
                if (cmd_other) o_cmd_error <= 1'b1;

                if (cmd_halt) begin
                    state     <= ST_IDLE;
                    free_run  <= 1'b0;
                    remaining <= '0;
                    o_done    <= 1'b1;
                end else if (bp_stop) begin
                    state      <= ST_IDLE;
                    free_run   <= 1'b0;
                    remaining  <= '0;
                    o_done     <= 1'b1;
                    o_bp_hit   <= 1'b1;
                    o_bp_index <= bp_match_idx;
                end else if (issue_en) begin
                    o_cycles   <= o_cycles + 1'b1;
                    first_tick <= 1'b0;
                    if (!free_run) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state  <= ST_IDLE;
                            o_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
